// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory bridge: opcodes, FSM encoding and
// the address auto-increment rule.
package spi_mem_pkg;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WR_DATA,
      RD_WAIT,
      RD_DATA,
      IGNORE
   } state_t;

   // Last valid word and any out-of-range address both wrap to 0.
   function automatic int next_addr(input int addr, input int depth);
      return (addr >= depth - 1) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/spi_mem_array.sv
// Single-port synchronous RAM with registered read data and a
// write-enable port.
module spi_mem_array #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // NOTE: storage has no reset; contents survive rst_n and power up undefined.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
   end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI-framed memory bridge: opcode, start address, then a burst of words
// written from MOSI or streamed back on MISO with one dummy cycle.
module spi_mem_bridge
   import spi_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic frame_err
);

   localparam int SHW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW  = $clog2(SHW) + 1;
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] DATA_FULL = CW'(DATA_WIDTH);

   state_t                state, state_d;
   logic [CW-1:0]         cnt, cnt_d;
   logic [SHW-2:0]        rx, rx_d, rx_shift;
   logic [DATA_WIDTH-1:0] tx, tx_d;
   logic [ADDR_WIDTH-1:0] addr, addr_d, wr_addr, wr_addr_d, mem_addr, rx_addr;
   logic [DATA_WIDTH-1:0] wr_data, wr_data_d, dout, rd_word, rx_word;
   logic [1:0]            opcode;
   logic                  wr_pend, wr_pend_d, is_read, is_read_d;
   logic                  armed, armed_d, oob, miso_d, err_d;

   assign rx_shift = {rx[SHW-3:0], MOSI};
   assign rx_addr  = {rx[ADDR_WIDTH-2:0], MOSI};
   assign rx_word  = {rx[DATA_WIDTH-2:0], MOSI};
   assign opcode   = {rx[0], MOSI};
   assign rd_word  = oob ? '0 : dout;

   // The first read is launched with the address still on the wire so the
   // word is ready for MISO at the end of the dummy cycle.
   always_comb begin
      if (wr_pend)                                mem_addr = wr_addr;
      else if (state == ADDR && cnt == ADDR_LAST) mem_addr = rx_addr;
      else                                        mem_addr = addr;
   end

   spi_mem_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk (clk),
      .we  (wr_pend),
      .addr(mem_addr),
      .din (wr_data),
      .dout(dout)
   );

   // NOTE: every output of this block gets a default first so no latch can form.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      rx_d      = rx;
      tx_d      = tx;
      addr_d    = addr;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      wr_pend_d = 1'b0;
      is_read_d = is_read;
      armed_d   = armed | SS_n;
      miso_d    = 1'b0;
      err_d     = 1'b0;
      if (SS_n) begin
         state_d = IDLE;
         cnt_d   = '0;
         err_d   = (state == CMD) || (state == ADDR) || (state == WR_DATA && cnt != '0);
      end else begin
         unique case (state)
            IDLE: if (armed) begin
               state_d = CMD;
               rx_d    = rx_shift;
               cnt_d   = '0;
            end
            CMD: begin
               if (opcode == OP_WRITE || opcode == OP_READ) begin
                  state_d   = ADDR;
                  is_read_d = (opcode == OP_READ);
               end else begin
                  state_d = IGNORE;
                  err_d   = 1'b1;
               end
            end
            ADDR: begin
               rx_d = rx_shift;
               if (cnt == ADDR_LAST) begin
                  cnt_d   = '0;
                  state_d = is_read ? RD_WAIT : WR_DATA;
                  addr_d  = is_read ? ADDR_WIDTH'(next_addr(int'(rx_addr), MEM_DEPTH)) : rx_addr;
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
            WR_DATA: begin
               rx_d = rx_shift;
               if (cnt == DATA_LAST) begin
                  cnt_d     = '0;
                  wr_pend_d = int'(addr) < MEM_DEPTH;
                  wr_addr_d = addr;
                  wr_data_d = rx_word;
                  addr_d    = ADDR_WIDTH'(next_addr(int'(addr), MEM_DEPTH));
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
            RD_WAIT: begin
               state_d = RD_DATA;
               miso_d  = rd_word[DATA_WIDTH-1];
               tx_d    = {rd_word[DATA_WIDTH-2:0], 1'b0};
               cnt_d   = CW'(1);
            end
            RD_DATA: begin
               if (cnt == DATA_FULL) begin
                  miso_d = rd_word[DATA_WIDTH-1];
                  tx_d   = {rd_word[DATA_WIDTH-2:0], 1'b0};
                  cnt_d  = CW'(1);
                  addr_d = ADDR_WIDTH'(next_addr(int'(addr), MEM_DEPTH));
               end else begin
                  miso_d = tx[DATA_WIDTH-1];
                  tx_d   = {tx[DATA_WIDTH-2:0], 1'b0};
                  cnt_d  = cnt + CW'(1);
               end
            end
            IGNORE:  state_d = IGNORE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // sees the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rx        <= '0;
         tx        <= '0;
         addr      <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_pend   <= 1'b0;
         is_read   <= 1'b0;
         armed     <= 1'b0;
         oob       <= 1'b0;
         MISO      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         rx        <= rx_d;
         tx        <= tx_d;
         addr      <= addr_d;
         wr_addr   <= wr_addr_d;
         wr_data   <= wr_data_d;
         wr_pend   <= wr_pend_d;
         is_read   <= is_read_d;
         armed     <= armed_d;
         oob       <= int'(mem_addr) >= MEM_DEPTH;
         MISO      <= miso_d;
         frame_err <= err_d;
      end
   end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge: directed frames plus a randomized
// mix, all checked against a word-level memory model.
module tb_spi_mem_bridge;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic SS_n  = 1'b1;
   logic MOSI  = 1'b0;
   logic MISO;
   logic frame_err;

   int n_checks   = 0;
   int n_errors   = 0;
   int err_pulses = 0;
   int miso_hi    = 0;

   logic [DW-1:0] mem_model [DEPTH];
   logic [DW-1:0] wq [$];

   spi_mem_bridge #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MEM_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bit period: drive at the falling edge, DUT samples on the rising
   // edge, outputs are observed at the next falling edge.
   task automatic tick(input logic ss, input logic mosi, output logic m);
      SS_n = ss;
      MOSI = mosi;
      @(negedge clk);
      if (frame_err) err_pulses++;
      m = MISO;
   endtask

   task automatic send(input logic [31:0] val, input int n);
      logic m;
      for (int i = n - 1; i >= 0; i--) begin
         tick(1'b0, val[i], m);
         if (m) miso_hi++;
      end
   endtask

   task automatic end_frame();
      logic m;
      tick(1'b1, 1'b0, m);
      tick(1'b1, 1'b0, m);
   endtask

   // Writes every queued word from address a, then `partial` stray bits.
   task automatic write_frame(input int a, input int partial, input string tag);
      int e0;
      int ad;
      e0      = err_pulses;
      miso_hi = 0;
      ad      = a;
      send(32'(2'b00), 2);
      send(32'(a), AW);
      foreach (wq[k]) begin
         send(32'(wq[k]), DW);
         if (ad < DEPTH) mem_model[ad] = wq[k];
         ad = (ad + 1) % DEPTH;
      end
      send($urandom, partial);
      end_frame();
      check({tag, "_err"}, 32'(err_pulses - e0), 32'(partial != 0));
      check({tag, "_miso"}, 32'(miso_hi), 32'd0);
   endtask

   // Reads nbits after the address; every whole word is compared.
   task automatic read_frame(input int a, input int nbits, input string tag);
      int e0;
      logic m;
      logic [DW-1:0] got;
      e0      = err_pulses;
      miso_hi = 0;
      got     = '0;
      send(32'(2'b01), 2);
      send(32'(a), AW);
      check({tag, "_pre_miso"}, 32'(miso_hi), 32'd0);
      for (int b = 0; b < nbits; b++) begin
         tick(1'b0, 1'($urandom), m);
         got = {got[DW-2:0], m};
         if (b % DW == DW - 1)
            check({tag, "_word"}, 32'(got), 32'(mem_model[(a + b / DW) % DEPTH]));
      end
      end_frame();
      check({tag, "_err"}, 32'(err_pulses - e0), 32'd0);
      check({tag, "_idle_miso"}, 32'(MISO), 32'd0);
   endtask

   // Asynchronous reset mid-frame, released with SS_n still low; a valid
   // looking WRITE of 0xEE to 0x30 is sent before SS_n ever rises.
   task automatic reset_mid_frame(input string tag);
      int e0;
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_rst_miso"}, 32'(MISO), 32'd0);
      check({tag, "_rst_err"}, 32'(frame_err), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      e0      = err_pulses;
      miso_hi = 0;
      send(32'({2'b00, 8'h30, 8'hEE}), 18);
      end_frame();
      check({tag, "_post_err"}, 32'(err_pulses - e0), 32'd0);
      check({tag, "_post_miso"}, 32'(miso_hi), 32'd0);
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int a;
      int kind;
      logic m;
      logic [1:0] op;

      #1 rst_n = 1'b0;
      #1;
      check("reset_miso", 32'(MISO), 32'd0);
      check("reset_err", 32'(frame_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      end_frame();

      // Fill the whole array so every later read has a known value.
      wq.delete();
      for (int i = 0; i < DEPTH; i++) wq.push_back(DW'($urandom));
      write_frame($urandom_range(0, DEPTH - 1), 0, "fill");

      wq = '{8'hA5, 8'h3C};
      write_frame(32'h10, 0, "w10");
      read_frame(32'h10, 16, "r10");

      wq = '{DW'($urandom), DW'($urandom)};
      write_frame(32'hFF, 0, "wwrap");
      read_frame(32'hFF, 16, "rwrap");

      wq.delete();
      write_frame(32'h20, 5, "wpart");
      read_frame(32'h20, 8, "rpart");

      // Reserved opcode: pulse right at the end of CMD, then silence.
      op      = 2'(2 + $urandom_range(0, 1));
      e0      = err_pulses;
      miso_hi = 0;
      tick(1'b0, op[1], m);
      tick(1'b0, op[0], m);
      check("rsv_pulse", 32'(frame_err), 32'd1);
      send(32'({2'b00, 8'h30, 8'hEE}), 18);
      check("rsv_miso", 32'(miso_hi), 32'd0);
      end_frame();
      check("rsv_err_count", 32'(err_pulses - e0), 32'd1);
      read_frame(32'h30, 8, "rsv_rd");

      e0 = err_pulses;
      send(32'(0), 1);
      end_frame();
      check("abort_cmd", 32'(err_pulses - e0), 32'd1);
      e0 = err_pulses;
      send(32'(2'b01), 2);
      send($urandom, 4);
      end_frame();
      check("abort_addr", 32'(err_pulses - e0), 32'd1);

      // Reset in the middle of a read burst while MISO is driving a 1.
      send(32'(2'b01), 2);
      send(32'h10, AW);
      tick(1'b0, 1'b0, m);
      tick(1'b0, 1'b0, m);
      tick(1'b0, 1'b0, m);
      check("rd_before_rst", 32'(m), 32'(mem_model[8'h10][DW-3]));
      reset_mid_frame("rst_rd");
      read_frame(32'h30, 8, "rst_rd_chk");

      // Reset in the middle of a write burst after two complete words.
      wq = '{DW'($urandom), DW'($urandom)};
      send(32'(2'b00), 2);
      send(32'h40, AW);
      foreach (wq[k]) begin
         send(32'(wq[k]), DW);
         mem_model[8'h40 + k] = wq[k];
      end
      send($urandom, 3);
      reset_mid_frame("rst_wr");
      read_frame(32'h40, 24, "rst_wr_chk");
      read_frame(32'h30, 8, "rst_wr_chk30");

      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 3);
         a    = $urandom_range(0, DEPTH - 1);
         if (kind <= 1) begin
            wq.delete();
            for (int j = 0; j < $urandom_range(1, 4); j++) wq.push_back(DW'($urandom));
            write_frame(a, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, DW - 1), "rnd_wr");
         end else if (kind == 2) begin
            read_frame(a, $urandom_range(1, 40), "rnd_rd");
         end else begin
            e0 = err_pulses;
            send(32'($urandom_range(0, 1)), 2);
            send($urandom, $urandom_range(1, AW - 1));
            end_frame();
            check("rnd_abort", 32'(err_pulses - e0), 32'd1);
         end
      end

      for (int a2 = 0; a2 < DEPTH; a2 += 64) read_frame(a2, 64 * DW, "final_rd");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_mem_bridge.md
SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width and SPI data word length in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: address field width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of words, with MEM_DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port SS_n, input, 1 bit: frame select, active-low.
REQ-007 SHALL have port MOSI, input, 1 bit: serial in, sampled on each clk edge while SS_n = 0.
REQ-008 SHALL have port MISO, output, 1 bit: serial out, registered.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on an aborted or illegal frame.

Function
REQ-010 SHALL sample frame bits MSB-first; bit 0 of a frame is the first edge with SS_n = 0 while in IDLE.
REQ-011 SHALL decode a frame as: 2-bit opcode, then ADDR_WIDTH-bit start address, then a burst of DATA_WIDTH-bit words.
REQ-012 SHALL decode opcodes as 00 = WRITE, 01 = READ, 10 and 11 = reserved.
REQ-013 SHALL implement FSM states IDLE, CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA and IGNORE.
REQ-014 SHALL take transitions IDLE->CMD on SS_n low; CMD->ADDR after 2 bits; ADDR->WR_DATA (WRITE) or ADDR->RD_WAIT (READ) after ADDR_WIDTH bits; RD_WAIT->RD_DATA after 1 cycle.
REQ-015 SHALL take CMD->IGNORE on a reserved opcode and pulse frame_err in the same cycle; IGNORE SHALL hold until SS_n = 1.
REQ-016 SHALL return any state to IDLE on the edge that samples SS_n = 1; SS_n high has priority over all other events.
REQ-017 SHALL, in WR_DATA, write each assembled word to the current address on the edge after its last bit; the written data SHALL be readable from the next cycle.
REQ-018 SHALL auto-increment the address after each word; MEM_DEPTH-1 SHALL wrap to 0.
REQ-019 SHALL, for an address >= MEM_DEPTH, drop writes, return 0 on reads, and make the next address 0.
REQ-020 SHALL issue the memory read in RD_WAIT (one dummy bit cycle); MISO SHALL carry word MSB from the edge ending RD_WAIT and change on each edge after.
REQ-021 SHALL return consecutive read words with no gap; the next word SHALL be prefetched before the current word's last bit.
REQ-022 SHALL, if SS_n rises with a partial WR_DATA word, discard that word (no write) and pulse frame_err.
REQ-023 SHALL, if SS_n rises in CMD or ADDR, pulse frame_err.
REQ-024 SHALL NOT treat SS_n rising at a word boundary or during RD_DATA/RD_WAIT as an error.
REQ-025 SHALL drive MISO = 0 in every state except RD_DATA.
REQ-026 SHALL keep bit counters at width $clog2(max(ADDR_WIDTH, DATA_WIDTH)) + 1.

Reset
REQ-027 SHALL, on rst_n low, immediately set the FSM to IDLE, MISO = 0, frame_err = 0, and clear counters, address and shift registers.
REQ-028 SHALL NOT reset memory contents.
REQ-029 SHALL make a reset mid-frame abort the frame with no write and no frame_err.
REQ-030 SHALL, after rst_n release with SS_n still low, wait for SS_n high before accepting a new frame.

Structure
REQ-031 SHALL place the opcode constants, the FSM state encoding and a next_addr wrap function in shared package spi_mem_pkg.
REQ-032 SHALL use sub-module spi_mem_array: single-port synchronous RAM, DATA_WIDTH x MEM_DEPTH, with we, addr, din, registered dout, and no reset.
REQ-033 SHALL keep the FSM, shifters and MISO register in spi_mem_bridge.

Verification
REQ-034 SHALL cover: WRITE frame 00, addr 0x10, words 0xA5 and 0x3C -> mem[0x10] = 0xA5, mem[0x11] = 0x3C, frame_err never asserted.
REQ-035 SHALL cover: READ frame 01, addr 0x10, 16 data cycles -> after 1 dummy cycle, MISO streams 0xA5 then 0x3C MSB-first with no gap.
REQ-036 SHALL cover: WRITE at addr 0xFF with 2 words (MEM_DEPTH = 256) -> mem[0xFF] and mem[0x00] written (wrap).
REQ-037 SHALL cover: WRITE addr 0x20, 5 data bits, then SS_n high -> mem[0x20] unchanged, frame_err pulses exactly 1 cycle.
REQ-038 SHALL cover: opcode 11 -> frame_err pulse at end of CMD, MISO = 0 and no writes until SS_n high.
REQ-039 SHALL cover: rst_n low mid-burst, then SS_n low -> IDLE, MISO = 0, the next valid frame works normally.
